// File: rtl/controller_sequencer.sv
// SAP-2 subset controller/sequencer: one-hot T1..T6 ring counter plus opcode decode driving the WBUS control word.
// Optional build macro CTRL_ILLEGAL_HALT_EN: unlisted opcodes halt and raise ILL instead of running as NOP.
module controller_sequencer (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] opcode,
    output logic [5:0] tstate,
    output logic       nLi,
    output logic       nEp,
    output logic       Cp,
    output logic       nLm,
    output logic       nCE,
    output logic       nLa,
    output logic       nEa,
    output logic       nLb,
    output logic       nEb,
    output logic       Su,
    output logic       nEu,
    output logic       nLo,
    output logic       HLT,
    output logic       ILL
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MVIA  = 8'h3E;
    localparam logic [7:0] OP_MVIB  = 8'h06;
    localparam logic [7:0] OP_MOVBA = 8'h47;
    localparam logic [7:0] OP_MOVAB = 8'h78;
    localparam logic [7:0] OP_ADDB  = 8'h80;
    localparam logic [7:0] OP_SUBB  = 8'h90;
    localparam logic [7:0] OP_OUT   = 8'hD3;
    localparam logic [7:0] OP_HLT   = 8'h76;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    typedef struct packed {
        logic nLi, nEp, Cp, nLm, nCE, nLa, nEa, nLb, nEb, Su, nEu, nLo;
    } ctl_t;

    localparam ctl_t CTL_IDLE = 12'b1101_1111_1011;

    tstate_e state, state_next;
    logic    halt_next;
    logic    ill_next;
    ctl_t    ctl;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        halt_next  = HLT;
        ill_next   = ILL;
        ctl        = CTL_IDLE;
        if (!HLT) begin
            unique case (state)
                T1: begin
                    ctl.nEp = 1'b0;
                    ctl.nLm = 1'b0;
                    state_next = T2;
                end
                T2: begin
                    ctl.Cp = 1'b1;
                    state_next = T3;
                end
                T3: begin
                    ctl.nCE = 1'b0;
                    ctl.nLi = 1'b0;
                    state_next = T4;
                end
                T4: begin
                    state_next = T1;
                    case (opcode)
                        OP_NOP: ;
                        OP_MVIA, OP_MVIB, OP_OUT: begin
                            ctl.nEp = 1'b0;
                            ctl.nLm = 1'b0;
                            state_next = T5;
                        end
                        OP_MOVBA: begin
                            ctl.nEa = 1'b0;
                            ctl.nLb = 1'b0;
                        end
                        OP_MOVAB: begin
                            ctl.nEb = 1'b0;
                            ctl.nLa = 1'b0;
                        end
                        OP_ADDB: begin
                            ctl.nEu = 1'b0;
                            ctl.nLa = 1'b0;
                        end
                        OP_SUBB: begin
                            ctl.Su  = 1'b1;
                            ctl.nEu = 1'b0;
                            ctl.nLa = 1'b0;
                        end
                        OP_HLT: begin
                            state_next = T4;
                            halt_next  = 1'b1;
                        end
                        default: begin
`ifdef CTRL_ILLEGAL_HALT_EN
                            state_next = T4;
                            halt_next  = 1'b1;
                            ill_next   = 1'b1;
`endif
                        end
                    endcase
                end
                T5: begin
                    ctl.Cp = 1'b1;
                    state_next = T6;
                end
                T6: begin
                    state_next = T1;
                    case (opcode)
                        OP_MVIA: begin
                            ctl.nCE = 1'b0;
                            ctl.nLa = 1'b0;
                        end
                        OP_MVIB: begin
                            ctl.nCE = 1'b0;
                            ctl.nLb = 1'b0;
                        end
                        OP_OUT: begin
                            ctl.nEa = 1'b0;
                            ctl.nLo = 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: state_next = T1;
            endcase
        end
    end

    // CLR forces every control inactive in the same cycle, not only after the edge.
    assign {nLi, nEp, Cp, nLm, nCE, nLa, nEa, nLb, nEb, Su, nEu, nLo} = CLR ? CTL_IDLE : ctl;
    assign tstate = state;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= T1;
            HLT   <= 1'b0;
        end else begin
            state <= state_next;
            HLT   <= halt_next;
        end
    end

`ifdef CTRL_ILLEGAL_HALT_EN
    always_ff @(posedge CLK) begin
        if (CLR) ILL <= 1'b0;
        else     ILL <= ill_next;
    end
`else
    assign ILL = 1'b0;
`endif

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: per-cycle vector table plus hand sequences for halt, abort and illegal opcode.
module tb_controller_sequencer;

    logic       CLK;
    logic       CLR;
    logic [7:0] opcode;
    logic [5:0] tstate;
    logic nLi, nEp, Cp, nLm, nCE, nLa, nEa, nLb, nEb, Su, nEu, nLo, HLT, ILL;
    logic [11:0] ctl;

    int total = 0;
    int bad   = 0;

    // Control word order: nLi nEp Cp nLm nCE nLa nEa nLb nEb Su nEu nLo
    localparam logic [11:0] C_IDLE  = 12'b110111111011;
    localparam logic [11:0] C_T1    = 12'b100011111011;
    localparam logic [11:0] C_T2    = 12'b111111111011;
    localparam logic [11:0] C_T3    = 12'b010101111011;
    localparam logic [11:0] C_MOVBA = 12'b110111001011;
    localparam logic [11:0] C_MOVAB = 12'b110110110011;
    localparam logic [11:0] C_ADD   = 12'b110110111001;
    localparam logic [11:0] C_SUB   = 12'b110110111101;
    localparam logic [11:0] C_MVIA6 = 12'b110100111011;
    localparam logic [11:0] C_MVIB6 = 12'b110101101011;
    localparam logic [11:0] C_OUT6  = 12'b110111011010;

    typedef struct {
        logic        clr;
        logic [7:0]  op;
        logic [5:0]  exp_t;
        logic [11:0] exp_ctl;
        logic        exp_hlt;
    } vec_t;

    vec_t vecs[$];

    controller_sequencer dut (
        .CLK(CLK), .CLR(CLR), .opcode(opcode), .tstate(tstate),
        .nLi(nLi), .nEp(nEp), .Cp(Cp), .nLm(nLm), .nCE(nCE), .nLa(nLa),
        .nEa(nEa), .nLb(nLb), .nEb(nEb), .Su(Su), .nEu(nEu), .nLo(nLo),
        .HLT(HLT), .ILL(ILL)
    );

    assign ctl = {nLi, nEp, Cp, nLm, nCE, nLa, nEa, nLb, nEb, Su, nEu, nLo};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from posedge.
    task automatic apply(input logic clr, input logic [7:0] op);
        @(negedge CLK);
        CLR    = clr;
        opcode = op;
        #1;
    endtask

    task automatic add(input logic [7:0] op, input logic [5:0] t, input logic [11:0] c);
        vec_t v;
        v.clr = 1'b0; v.op = op; v.exp_t = t; v.exp_ctl = c; v.exp_hlt = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic fetch(input logic [7:0] op);
        add(op, 6'h01, C_T1);
        add(op, 6'h02, C_T2);
        add(op, 6'h04, C_T3);
    endtask

    task automatic run_fetch();
        apply(1'b0, 8'h00);
        apply(1'b0, 8'h00);
        apply(1'b0, 8'h00);
    endtask

    logic lo_seen;

    initial begin
        CLR = 1'b1;
        opcode = 8'h00;

        // Opcode garbage during fetch (8'h76) must not disturb the sequence.
        fetch(8'h00); add(8'h00, 6'h08, C_IDLE);
        fetch(8'h76); add(8'h3E, 6'h08, C_T1); add(8'h3E, 6'h10, C_T2); add(8'h3E, 6'h20, C_MVIA6);
        fetch(8'hD3); add(8'h06, 6'h08, C_T1); add(8'h06, 6'h10, C_T2); add(8'h06, 6'h20, C_MVIB6);
        fetch(8'h00); add(8'h47, 6'h08, C_MOVBA);
        fetch(8'h00); add(8'h78, 6'h08, C_MOVAB);
        fetch(8'h00); add(8'h80, 6'h08, C_ADD);
        fetch(8'h00); add(8'h90, 6'h08, C_SUB);
        fetch(8'h00); add(8'hD3, 6'h08, C_T1); add(8'hD3, 6'h10, C_T2); add(8'hD3, 6'h20, C_OUT6);
        add(8'h00, 6'h01, C_T1);

        // Reset: two cycles of CLR.
        apply(1'b1, 8'h00);
        apply(1'b1, 8'h00);
        check("reset tstate", 32'(tstate), 32'h01);
        check("reset HLT", 32'(HLT), 32'h0);
        check("reset ILL", 32'(ILL), 32'h0);
        check("reset ctl", 32'(ctl), 32'(C_IDLE));

        foreach (vecs[i]) begin
            apply(vecs[i].clr, vecs[i].op);
            check($sformatf("row%0d tstate", i), 32'(tstate), 32'(vecs[i].exp_t));
            check($sformatf("row%0d ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
            check($sformatf("row%0d HLT", i), 32'(HLT), 32'(vecs[i].exp_hlt));
        end

        // HLT: freezes at T4 with controls idle regardless of opcode, only CLR exits.
        apply(1'b1, 8'h00);
        run_fetch();
        apply(1'b0, 8'h76);
        check("hlt T4 HLT", 32'(HLT), 32'h0);
        check("hlt T4 ctl", 32'(ctl), 32'(C_IDLE));
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, i[0] ? 8'h3E : 8'h76);
            check($sformatf("hlt%0d tstate", i), 32'(tstate), 32'h08);
            check($sformatf("hlt%0d HLT", i), 32'(HLT), 32'h1);
            check($sformatf("hlt%0d ctl", i), 32'(ctl), 32'(C_IDLE));
        end
        apply(1'b1, 8'h00);
        check("hlt clr ctl", 32'(ctl), 32'(C_IDLE));
        apply(1'b0, 8'h00);
        check("hlt exit tstate", 32'(tstate), 32'h01);
        check("hlt exit HLT", 32'(HLT), 32'h0);

        // OUT aborted by CLR in T5: nLo never asserts, restart at T1.
        lo_seen = 1'b0;
        apply(1'b1, 8'h00);
        run_fetch();
        apply(1'b0, 8'hD3);
        lo_seen |= ~nLo;
        check("abort T4 ctl", 32'(ctl), 32'(C_T1));
        apply(1'b1, 8'hD3);
        lo_seen |= ~nLo;
        check("abort T5 tstate", 32'(tstate), 32'h10);
        check("abort T5 ctl", 32'(ctl), 32'(C_IDLE));
        apply(1'b0, 8'hD3);
        lo_seen |= ~nLo;
        check("abort restart tstate", 32'(tstate), 32'h01);
        apply(1'b0, 8'hD3);
        lo_seen |= ~nLo;
        check("abort next tstate", 32'(tstate), 32'h02);
        check("abort nLo never low", 32'(lo_seen), 32'h0);

        // Illegal opcode 8'hFF.
        apply(1'b1, 8'h00);
        run_fetch();
        apply(1'b0, 8'hFF);
        check("ill T4 tstate", 32'(tstate), 32'h08);
        check("ill T4 ctl", 32'(ctl), 32'(C_IDLE));
        check("ill T4 ILL", 32'(ILL), 32'h0);
`ifdef CTRL_ILLEGAL_HALT_EN
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 8'h00);
            check($sformatf("ill%0d tstate", i), 32'(tstate), 32'h08);
            check($sformatf("ill%0d HLT", i), 32'(HLT), 32'h1);
            check($sformatf("ill%0d ILL", i), 32'(ILL), 32'h1);
            check($sformatf("ill%0d ctl", i), 32'(ctl), 32'(C_IDLE));
        end
        apply(1'b1, 8'h00);
        apply(1'b0, 8'h00);
        check("ill clr tstate", 32'(tstate), 32'h01);
        check("ill clr ILL", 32'(ILL), 32'h0);
        check("ill clr HLT", 32'(HLT), 32'h0);
`else
        apply(1'b0, 8'hFF);
        check("ill nop tstate", 32'(tstate), 32'h01);
        check("ill nop ctl", 32'(ctl), 32'(C_T1));
        check("ill nop ILL", 32'(ILL), 32'h0);
        check("ill nop HLT", 32'(HLT), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Consumer end of the instruction-register interface: reads the 8-bit opcode held in the IR and generates the control word that drives the WBUS.
- Includes nLi, the control that loads the IR, so this block and the IR form one loop.
- A one-hot T-state ring counter (T1..T6) with a variable-length machine cycle.
- Decodes a SAP-2 subset with 8080-compatible opcodes.

Parameters:
OP_NOP, 8'h00, no operation
OP_MVIA, 8'h3E, MVI A,byte
OP_MVIB, 8'h06, MVI B,byte
OP_MOVBA, 8'h47, MOV B,A
OP_MOVAB, 8'h78, MOV A,B
OP_ADDB, 8'h80, ADD B
OP_SUBB, 8'h90, SUB B
OP_OUT, 8'hD3, OUT byte (port byte fetched and discarded, A to output port)
OP_HLT, 8'h76, halt

Ports:
CLK  in  1  clock, all state changes on posedge
CLR  in  1  synchronous reset, active-high
opcode  in  8  from IR
tstate  out  6  one-hot T-state, bit0=T1 .. bit5=T6
nLi  out  1  load IR, 0=load
nEp  out  1  PC onto WBUS, 0=enable
Cp  out  1  increment PC, 1=inc
nLm  out  1  load MAR, 0=load
nCE  out  1  memory onto WBUS, 0=enable
nLa  out  1  load A, 0=load
nEa  out  1  A onto WBUS, 0=enable
nLb  out  1  load B, 0=load
nEb  out  1  B onto WBUS, 0=enable
Su  out  1  ALU subtract, 1=sub
nEu  out  1  ALU onto WBUS, 0=enable
nLo  out  1  load output port, 0=load
HLT  out  1  halted flag (registered)
ILL  out  1  illegal opcode seen (only with option; else tied 0)

Behaviour:
- Interface: one clock (CLK); reset CLR is synchronous and active-high.
- Reset: on a posedge with CLR=1, tstate=6'b000001 and HLT=0 (ILL=0 with option). CLR has priority over everything, including halt. While CLR=1, all controls are inactive: active-low outputs=1, Cp=0, Su=0.
- Control outputs are combinational from the registered tstate, opcode and HLT. Only one-hot tstate and the HLT/ILL flags are registered.
- Inactive default: all active-low outputs=1, Cp=0, Su=0.
- Fetch, common to all instructions:
  - T1: nEp=0, nLm=0.
  - T2: Cp=1.
  - T3: nCE=0, nLi=0. The IR captures at the end of T3, so opcode is valid from T4.
- Execute:
  - NOP: T4 idle, then T1.
  - MOV B,A: T4 nEa=0, nLb=0, then T1.
  - MOV A,B: T4 nEb=0, nLa=0, then T1.
  - ADD B: T4 Su=0, nEu=0, nLa=0, then T1.
  - SUB B: T4 Su=1, nEu=0, nLa=0, then T1.
  - MVI A: T4 nEp=0, nLm=0; T5 Cp=1; T6 nCE=0, nLa=0; then T1.
  - MVI B: same as MVI A with nLb=0 in T6 instead of nLa.
  - OUT: T4 nEp=0, nLm=0; T5 Cp=1; T6 nEa=0, nLo=0; then T1.
  - HLT: in T4, HLT is set at the posedge and tstate holds at T4. While HLT=1, all controls are inactive and the counter is frozen; only CLR exits.
  - Unlisted opcode: executes as NOP (4 cycles), without the option.
- Ring counter:
  - T1→T2→T3→T4 unconditionally.
  - From T4: to T1 for 4-cycle ops, to T5 for MVI/OUT, hold for HLT.
  - T5→T6, then T6→T1.
  - tstate is never zero and never multi-hot. An illegal tstate value (not reachable) recovers to T1 on the next edge.
- Opcode changes outside T4..T6 have no effect on the sequence.
- CLR mid-instruction aborts it; the next cycle after CLR deasserts is T1.
- Cycle counts: NOP/MOV/ADD/SUB = 4 cycles; MVI/OUT = 6 cycles; HLT = 4 cycles, then frozen.

Optional Feature:
- Macro: CTRL_ILLEGAL_HALT_EN.
- Defined: an unlisted opcode in T4 sets both ILL and HLT at that posedge and freezes like HLT. ILL is cleared only by CLR.
- Undefined: ILL is tied 0 and unlisted opcodes execute as NOP.

Test Plan:
- Reset and NOP: CLR=1 for 2 cycles, then 0, opcode=8'h00. Required: tstate 01,02,04,08,01; nEp=nLm=0 only in T1, Cp=1 only in T2, nLi=nCE=0 only in T3.
- MVI A: opcode=8'h3E from T4. Required: tstate reaches T6 (6'h20) then 01; T4 nEp=nLm=0, T5 Cp=1, T6 nCE=0 and nLa=0; total 6 cycles.
- ADD then SUB: opcode=8'h80, then 8'h90. Required: T4 shows nEu=0, nLa=0 with Su=0, then Su=1; each instruction is 4 cycles.
- HLT: opcode=8'h76. Required: HLT=1 after the T4 edge; tstate stays 6'h08 for 10+ cycles with all controls inactive; CLR=1 returns tstate=01 and HLT=0.
- Reset mid-instruction: CLR=1 during T5 of OUT (8'hD3). Required: nLo is never asserted; tstate=01 on the next cycle after CLR deasserts.
- Illegal opcode 8'hFF: without the option, 4-cycle NOP and ILL=0; with CTRL_ILLEGAL_HALT_EN, ILL=1 and HLT=1 after T4, counter frozen.
